// File: rtl/iob_cpu_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : iob_cpu_bus_arbiter_if
// Brief  : IOb native bus bundle: packed request {valid,addr,wdata,wstrb} and
//          packed response {rdata,ready}.
// Rev    : 1.0  initial release
// ============================================================================
interface iob_cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;

    logic [REQ_W-1:0]  req;
    logic [RESP_W-1:0] resp;

    // master issues requests, slave answers them
    modport master (output req, input  resp);
    modport slave  (input  req, output resp);
endinterface
`default_nettype wire

// File: rtl/iob_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : iob_cpu_bus_arbiter
// Brief  : Round-robin arbiter merging the CPU instruction and data buses onto
//          one IOb slave port, one captured transaction outstanding at a time.
// Rev    : 1.0  initial release
// ============================================================================
module iob_cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire                   clk,
    input  wire                   rst,
    iob_cpu_bus_arbiter_if.slave  ibus,
    iob_cpu_bus_arbiter_if.slave  dbus,
    iob_cpu_bus_arbiter_if.master mem,
    output logic                  busy,
    output logic                  grant
);
    localparam int C_STRB_W = DATA_W / 8;
    localparam int C_REQ_W  = 1 + ADDR_W + DATA_W + C_STRB_W;
    localparam int C_RESP_W = DATA_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic                grant_q,  grant_d;
    logic                last_q,   last_d;
    logic                valid_q,  valid_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [C_STRB_W-1:0] wstrb_q,  wstrb_d;

    logic                w_ibus_valid;
    logic                w_dbus_valid;
    logic                w_sel;
    logic [C_REQ_W-1:0]  w_sel_req;
    logic                w_fire;

    assign w_ibus_valid = ibus.req[C_REQ_W-1];
    assign w_dbus_valid = dbus.req[C_REQ_W-1];

    // On a tie the master that was not served last wins
    assign w_sel     = (w_ibus_valid & w_dbus_valid) ? ~last_q : w_dbus_valid;
    assign w_sel_req = w_sel ? dbus.req : ibus.req;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (w_ibus_valid | w_dbus_valid) begin
                    state_d = ST_BUSY;
                    grant_d = w_sel;
                    last_d  = w_sel;
                    valid_d = 1'b1;
                    addr_d  = w_sel_req[C_REQ_W-2 -: ADDR_W];
                    wdata_d = w_sel_req[C_STRB_W+DATA_W-1 -: DATA_W];
                    wstrb_d = w_sel_req[C_STRB_W-1:0];
                end
            end
            ST_BUSY: begin
                if (mem.resp[0]) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Slave ready only counts while a transaction is outstanding
    assign w_fire = (state_q == ST_BUSY) & mem.resp[0];

    assign mem.req   = (state_q == ST_BUSY) ? {valid_q, addr_q, wdata_q, wstrb_q} : '0;
    assign ibus.resp = (w_fire & ~grant_q) ? {mem.resp[C_RESP_W-1:1], 1'b1} : '0;
    assign dbus.resp = (w_fire &  grant_q) ? {mem.resp[C_RESP_W-1:1], 1'b1} : '0;
    assign busy      = (state_q == ST_BUSY);
    assign grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_iob_cpu_bus_arbiter
// Brief  : Directed and random stimulus against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_iob_cpu_bus_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;

    logic clk;
    logic rst;
    logic busy;
    logic grant;

    iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ibus_if ();
    iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbus_if ();
    iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    iob_cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .ibus  (ibus_if),
        .dbus  (dbus_if),
        .mem   (mem_if),
        .busy  (busy),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one captured request, who owns it, who won last
    bit               m_busy;
    bit               m_who;
    bit               m_last;
    logic [REQ_W-1:0] m_cap;
    int               scnt;

    int               slave_mode;  // 0 manual, 1 fixed latency, 2 random
    int               lat;
    logic [DW-1:0]    slave_rdata;
    bit               hold_mode;   // masters drop valid after their ready
    int               cyc;
    bit               busy_prev;
    int               gq[$];
    int               rise_q[$];
    int               rdy_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input bit v, input logic [AW-1:0] a,
                                                input logic [DW-1:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_who = 0; m_last = 0; m_cap = '0; scnt = 0; busy_prev = 0;
    endtask

    task automatic clear_logs();
        gq.delete(); rise_q.delete(); rdy_q.delete();
    endtask

    // Called at a falling edge with master inputs already applied
    task automatic step();
        logic [REQ_W-1:0]  em;
        logic [RESP_W-1:0] ei, ed;
        bit                rdy, iv, dv, gi, gd;
        if (slave_mode == 1)
            mem_if.resp = {slave_rdata, (m_busy && scnt == lat)};
        else if (slave_mode == 2)
            mem_if.resp = {DW'($urandom), ($urandom_range(0, 2) == 0)};
        #1;
        rdy = mem_if.resp[0];
        em  = m_busy ? m_cap : '0;
        ei  = (m_busy && rdy && !m_who) ? {mem_if.resp[RESP_W-1:1], 1'b1} : '0;
        ed  = (m_busy && rdy &&  m_who) ? {mem_if.resp[RESP_W-1:1], 1'b1} : '0;
        chk("mem_req",   128'(mem_if.req),  128'(em));
        chk("ibus_resp", 128'(ibus_if.resp), 128'(ei));
        chk("dbus_resp", 128'(dbus_if.resp), 128'(ed));
        chk("busy",      128'(busy),  128'(m_busy));
        chk("grant",     128'(grant), 128'(m_who));
        if (busy && !busy_prev) begin gq.push_back(int'(grant)); rise_q.push_back(cyc); end
        gi = ibus_if.resp[0];
        gd = dbus_if.resp[0];
        if (gi || gd) rdy_q.push_back(cyc);
        busy_prev = busy;
        iv = ibus_if.req[REQ_W-1];
        dv = dbus_if.req[REQ_W-1];
        @(posedge clk);
        if (m_busy) begin
            if (rdy) m_busy = 0;
            scnt = rdy ? 0 : scnt + 1;
        end else if (iv || dv) begin
            m_who  = (iv && dv) ? !m_last : dv;
            m_last = m_who;
            m_cap  = m_who ? dbus_if.req : ibus_if.req;
            m_busy = 1;
            scnt   = 0;
        end
        cyc++;
        @(negedge clk);
        if (hold_mode && gi) ibus_if.req = '0;
        if (hold_mode && gd) dbus_if.req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ibus_if.req = '0;
        dbus_if.req = '0;
        mem_if.resp = '0;
        model_reset();
        @(negedge clk);
        chk("rst_mem_req", 128'(mem_if.req), 128'(0));
        chk("rst_busy",    128'(busy),  128'(0));
        chk("rst_grant",   128'(grant), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        clear_logs();
    endtask

    initial begin
        int t;
        int ones;
        slave_mode = 1; lat = 1; slave_rdata = '0; hold_mode = 1; cyc = 0;
        do_reset();

        // Single instruction fetch with a 3-cycle slave
        lat = 2; slave_rdata = 32'hDEADBEEF; hold_mode = 1;
        ibus_if.req = mk_req(1'b1, 32'h80, 32'h0, 4'h0);
        t = cyc;
        repeat (6) step();
        if (rise_q.size() >= 1 && rdy_q.size() >= 1) begin
            chk("ibus_req_lat", 128'(rise_q[0] - t), 128'(1));
            chk("ibus_rdy_cyc", 128'(rdy_q[0] - t),  128'(3));
        end else chk("ibus_txn_seen", 128'(0), 128'(1));

        // Simultaneous requests from reset release
        do_reset();
        lat = 1; slave_rdata = 32'h0BADF00D;
        ibus_if.req = mk_req(1'b1, 32'h10,  32'h0,        4'h0);
        dbus_if.req = mk_req(1'b1, 32'h200, 32'h12345678, 4'hF);
        repeat (8) step();
        if (gq.size() >= 2 && rise_q.size() >= 2 && rdy_q.size() >= 1) begin
            chk("sim_grant0", 128'(gq[0]), 128'(1));
            chk("sim_grant1", 128'(gq[1]), 128'(0));
            chk("sim_b2b_gap", 128'(rise_q[1] - rdy_q[0]), 128'(2));
        end else chk("sim_txn_seen", 128'(0), 128'(1));

        // Continuous contention
        do_reset();
        hold_mode = 0; lat = 1;
        ibus_if.req = mk_req(1'b1, 32'h44, 32'h0, 4'h0);
        dbus_if.req = mk_req(1'b1, 32'h88, 32'h55AA55AA, 4'h3);
        repeat (31) step();
        chk("cont_n_txn", 128'(gq.size() >= 10), 128'(1));
        ones = 0;
        for (int k = 0; k < 10 && k < gq.size(); k++) begin
            chk("cont_alt", 128'(gq[k]), 128'((k % 2 == 0) ? 1 : 0));
            ones += gq[k];
        end
        chk("cont_dbus_cnt", 128'(ones), 128'(5));

        // Field stability: granted dbus wiggles its lines while busy
        ibus_if.req = '0; dbus_if.req = '0;
        repeat (3) step();
        hold_mode = 1; lat = 3;
        dbus_if.req = mk_req(1'b1, 32'h300, 32'h11112222, 4'hF);
        for (int k = 0; k < 7; k++) begin
            if (m_busy && dbus_if.req[REQ_W-1])
                dbus_if.req[REQ_W-2:0] = {32'($urandom), 32'($urandom), 4'($urandom)};
            step();
        end

        // Spurious slave ready while idle
        slave_mode = 0;
        ibus_if.req = '0; dbus_if.req = '0;
        mem_if.resp = {32'hFEEDFACE, 1'b1};
        repeat (3) step();
        chk("spur_busy", 128'(busy), 128'(0));

        // Reset mid-transaction
        mem_if.resp = '0;
        hold_mode = 0;
        dbus_if.req = mk_req(1'b1, 32'h100, 32'h0000CAFE, 4'hF);
        repeat (2) step();
        dbus_if.req = '0;
        mem_if.resp = {32'h13572468, 1'b1};
        rst = 1'b1;
        #1;
        chk("arst_mem_req", 128'(mem_if.req),   128'(0));
        chk("arst_busy",    128'(busy),         128'(0));
        chk("arst_dbus",    128'(dbus_if.resp), 128'(0));
        @(negedge clk);
        do_reset();
        slave_mode = 1; lat = 1; hold_mode = 1;
        ibus_if.req = mk_req(1'b1, 32'h20,  32'h0,  4'h0);
        dbus_if.req = mk_req(1'b1, 32'h104, 32'h99, 4'h1);
        repeat (4) step();
        if (gq.size() >= 1) chk("arst_first_tie", 128'(gq[0]), 128'(1));
        else chk("arst_txn_seen", 128'(0), 128'(1));

        // Random traffic with a random-latency slave
        do_reset();
        slave_mode = 2; hold_mode = 0;
        for (int k = 0; k < 400; k++) begin
            ibus_if.req = mk_req(($urandom_range(0, 3) != 0), 32'($urandom), 32'($urandom), 4'($urandom));
            dbus_if.req = mk_req(($urandom_range(0, 3) != 0), 32'($urandom), 32'($urandom), 4'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
